// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame store.
// The FILL state and colour-bar table are only used when FB_TESTPAT_EN is defined.
package fb_pkg;

  localparam int unsigned PIXEL_W = 24;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT_SWAP,
    FILL
  } fb_state_e;

  // Vertical bars left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam pixel_t BAR_COLOUR [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM holding both frame buffers; address MSB selects the buffer.
// One write port, one registered read port whose output register resets to zero.
module fb_dpram #(
  parameter int unsigned AW   = 19,
  parameter int unsigned DW   = 24,
  parameter int unsigned HALF = 480000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW:0]   wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW:0]   rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 * HALF;
  localparam int unsigned IW    = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  // Buffers are packed back to back, so buffer 1 starts at HALF rather than 2**AW.
  function automatic logic [IW-1:0] lin(input logic [AW:0] a);
    return IW'(a[AW-1:0]) + (a[AW] ? IW'(HALF) : '0);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[lin(wr_addr)] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[lin(rd_addr)];
  end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered frame store: writes the back buffer, serves scan-out from the front
// buffer, swaps on VGA vsync. Define FB_TESTPAT_EN to add the tp_req colour-bar fill.
module frame_buffer_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned H_DISP = 800,
  parameter int unsigned V_DISP = 600,
  parameter int unsigned PIX_W  = 24,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_data,
  input  logic              in_sof,
  input  logic              vga_vs,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              front_sel,
  output logic              frame_done,
  output logic              sof_err
`ifdef FB_TESTPAT_EN
  ,
  input  logic              tp_req
`endif
);

  localparam int unsigned       NPIX = H_DISP * V_DISP;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  fb_state_e         state, state_next;
  logic [ADDR_W-1:0] wr_addr, wr_ptr;
  logic [PIX_W-1:0]  wr_dat, ram_q;
  logic              wr_en, rdy_en, rd_ok_q;
  logic              vs_sync, vs_prev, vs_fall;
  logic              accept, at_last, start_fill, swap;

`ifdef FB_TESTPAT_EN
  localparam int unsigned BAR_W = H_DISP / 8;
  localparam int unsigned XW    = $clog2(H_DISP);
  logic [XW-1:0]    x_cnt;
  logic [2:0]       bar;
  logic [PIX_W-1:0] fill_pix;

  assign start_fill = (state == IDLE) && tp_req;
  assign bar        = 3'(32'(x_cnt) / BAR_W);
  assign fill_pix   = PIX_W'(BAR_COLOUR[bar]);
`else
  assign start_fill = 1'b0;
`endif

  // vga_vs is registered before the edge compare, so a swap lands two clocks after vsync falls
  assign vs_fall = vs_prev & ~vs_sync;
  assign accept  = in_valid & in_ready;
  assign at_last = (wr_addr == LAST);
  assign swap    = (state == WAIT_SWAP) && vs_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_fill)           state_next = FILL;
        else if (accept && in_sof) state_next = WRITE;
      end
      WRITE:     if (accept && !in_sof && at_last) state_next = WAIT_SWAP;
      WAIT_SWAP: if (vs_fall) state_next = IDLE;
`ifdef FB_TESTPAT_EN
      FILL:      if (at_last) state_next = WAIT_SWAP;
`endif
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = rdy_en && (state == IDLE || state == WRITE) && !start_fill;
    wr_en    = 1'b0;
    wr_ptr   = wr_addr;
    wr_dat   = in_data;
    case (state)
      IDLE: begin
        if (in_valid && in_ready && in_sof) begin
          wr_en  = 1'b1;
          wr_ptr = '0;
        end
      end
      WRITE: begin
        if (in_valid && in_ready) begin
          wr_en = 1'b1;
          if (in_sof) wr_ptr = '0;
        end
      end
`ifdef FB_TESTPAT_EN
      FILL: begin
        wr_en  = 1'b1;
        wr_dat = fill_pix;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en     <= 1'b0;
      wr_addr    <= '0;
      vs_sync    <= 1'b1;
      vs_prev    <= 1'b1;
      front_sel  <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      rdy_en     <= 1'b1;
      vs_sync    <= vga_vs;
      vs_prev    <= vs_sync;
      frame_done <= swap;
      rd_ok_q    <= (32'(rd_addr) < 32'(NPIX));
      if (swap) front_sel <= ~front_sel;
      if ((state == WRITE) && accept && in_sof) sof_err <= 1'b1;
      // wr_ptr already folds in the restart-at-zero case, so one increment covers all writers
      if (start_fill) wr_addr <= '0;
      else if (wr_en) wr_addr <= wr_ptr + ADDR_W'(1);
    end
  end

`ifdef FB_TESTPAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                x_cnt <= '0;
    else if (start_fill)       x_cnt <= '0;
    else if (state == FILL)    x_cnt <= (32'(x_cnt) == H_DISP - 1) ? '0 : x_cnt + XW'(1);
  end
`endif

  fb_dpram #(
    .AW   (ADDR_W),
    .DW   (PIX_W),
    .HALF (NPIX)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr ({~front_sel, wr_ptr}),
    .wr_data (wr_dat),
    .rd_addr ({front_sel, rd_addr}),
    .rd_data (ram_q)
  );

  assign rd_data = rd_ok_q ? ram_q : '0;

endmodule
